// File: rtl/checked_adder_sequencer.sv
// -----------------------------------------------------------------------------
// checked_adder_sequencer
//
// Sequencer for the duplicated, self-checking 3-bit add/subtract datapath.
// A request (operands + op code) is taken over a valid/ready handshake. The
// sequencer then drives the datapath operands, parity and one-hot op code. It
// holds them for SETTLE_CYC cycles and then checks both result copies (X/Y) and
// both two-rail error codes. On a detected error the operation is re-issued, up
// to MAX_RETRY times, before the result is returned with a status code.
//
// Optional feature macro: CHK_ERR_CNT_EN
//   When defined, adds a saturating error counter (err_cnt) and its
//   synchronous clear input (err_cnt_clr).
//
// Ports
//   clk          in   1         rising-edge clock
//   rst_n        in   1         asynchronous active-low reset
//   req_valid    in   1         request present
//   req_ready    out  1         sequencer can accept (IDLE only)
//   req_a        in   3         operand A
//   req_b        in   3         operand B
//   req_op       in   2         00 A+B, 01 A-B, 10 B-A, 11 illegal
//   dp_a         out  3         datapath operand A
//   dp_b         out  3         datapath operand B
//   dp_par       out  1         parity over {dp_a, dp_b}
//   dp_c         out  3         one-hot op code, 000 when idle
//   dp_x         in   4         result copy X {XC,X2,X1,X0}
//   dp_xe        in   2         X two-rail error code, 2'b10 = no error
//   dp_y         in   4         result copy Y {YC,Y2,Y1,Y0}
//   dp_ye        in   2         Y two-rail error code, 2'b10 = no error
//   rsp_valid    out  1         response present
//   rsp_ready    in   1         response consumed
//   rsp_sum      out  4         dp_x captured on the final attempt
//   rsp_status   out  2         00 ok, 01 ok after retry, 10 failed, 11 illegal
//   rsp_retries  out  2         re-issues used
//   err_cnt_clr  in   1         (CHK_ERR_CNT_EN) synchronous clear of err_cnt
//   err_cnt      out  ERRCNT_W  (CHK_ERR_CNT_EN) failed-sample count, saturating
// -----------------------------------------------------------------------------
module checked_adder_sequencer #(
   parameter int MAX_RETRY  = 2,
   parameter int SETTLE_CYC = 1,
   parameter int ERRCNT_W   = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic [2:0]          req_a,
   input  logic [2:0]          req_b,
   input  logic [1:0]          req_op,
   output logic [2:0]          dp_a,
   output logic [2:0]          dp_b,
   output logic                dp_par,
   output logic [2:0]          dp_c,
   input  logic [3:0]          dp_x,
   input  logic [1:0]          dp_xe,
   input  logic [3:0]          dp_y,
   input  logic [1:0]          dp_ye,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [3:0]          rsp_sum,
   output logic [1:0]          rsp_status,
   output logic [1:0]          rsp_retries
`ifdef CHK_ERR_CNT_EN
   ,
   input  logic                err_cnt_clr,
   output logic [ERRCNT_W-1:0] err_cnt
`endif
);

   localparam int            SW          = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
   localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYC - 1);
   localparam logic [1:0]    MAX_R       = 2'(MAX_RETRY);

   localparam logic [1:0] ST_OK       = 2'b00;
   localparam logic [1:0] ST_OK_RETRY = 2'b01;
   localparam logic [1:0] ST_FAILED   = 2'b10;
   localparam logic [1:0] ST_ILLEGAL  = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_DRIVE  = 2'd1,
      S_SAMPLE = 2'd2,
      S_RESP   = 2'd3
   } state_t;

   state_t        state;
   state_t        state_nxt;
   logic [SW-1:0] settle_cnt;
   logic [1:0]    retries;
   logic          sample_pass;
   logic          retry_ok;

   function automatic logic [2:0] op_onehot(input logic [1:0] op);
      logic [2:0] c;
      case (op)
         2'b00:   c = 3'b001;
         2'b01:   c = 3'b010;
         2'b10:   c = 3'b100;
         default: c = 3'b000;
      endcase
      return c;
   endfunction

`ifdef CHK_ERR_CNT_EN
   function automatic logic [ERRCNT_W-1:0] sat_inc(input logic [ERRCNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction
`endif

   // Both copies must agree and both two-rail checkers must report "no error".
   assign sample_pass = (dp_xe == 2'b10) && (dp_ye == 2'b10) && (dp_x == dp_y);
   assign retry_ok    = (retries < MAX_R);

   // ---- state register ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // ---- next-state logic ----
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   if (req_valid) state_nxt = (req_op == 2'b11) ? S_RESP : S_DRIVE;
         S_DRIVE:  if (settle_cnt == '0) state_nxt = S_SAMPLE;
         S_SAMPLE: state_nxt = (sample_pass || !retry_ok) ? S_RESP : S_DRIVE;
         S_RESP:   if (rsp_ready) state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   // ---- state-decoded outputs ----
   always_comb begin
      req_ready = (state == S_IDLE);
      rsp_valid = (state == S_RESP);
   end

   // ---- datapath drive, settle/retry counters, response capture ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dp_a        <= '0;
         dp_b        <= '0;
         dp_par      <= 1'b0;
         dp_c        <= '0;
         settle_cnt  <= '0;
         retries     <= '0;
         rsp_sum     <= '0;
         rsp_status  <= '0;
         rsp_retries <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (req_valid) begin
                  retries <= '0;
                  if (req_op == 2'b11) begin
                     // Illegal op: answer directly, the datapath stays idle.
                     rsp_sum     <= '0;
                     rsp_status  <= ST_ILLEGAL;
                     rsp_retries <= '0;
                  end else begin
                     dp_a       <= req_a;
                     dp_b       <= req_b;
                     dp_par     <= ^{req_a, req_b};
                     dp_c       <= op_onehot(req_op);
                     settle_cnt <= SETTLE_LOAD;
                  end
               end
            end
            S_DRIVE: begin
               if (settle_cnt != '0) settle_cnt <= settle_cnt - 1'b1;
            end
            S_SAMPLE: begin
               // Operands stay on the datapath across a retry; only the
               // settle window restarts.
               rsp_sum     <= dp_x;
               rsp_retries <= retries;
               if (sample_pass) begin
                  rsp_status <= (retries == 2'd0) ? ST_OK : ST_OK_RETRY;
               end else if (retry_ok) begin
                  retries    <= retries + 2'd1;
                  settle_cnt <= SETTLE_LOAD;
               end else begin
                  rsp_status <= ST_FAILED;
               end
            end
            S_RESP: begin
               if (rsp_ready) dp_c <= '0;
            end
            default: ;
         endcase
      end
   end

`ifdef CHK_ERR_CNT_EN
   // ---- error counter: one count per failed sample, clear has priority ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                  err_cnt <= '0;
      else if (err_cnt_clr)                        err_cnt <= '0;
      else if ((state == S_SAMPLE) && !sample_pass) err_cnt <= sat_inc(err_cnt);
   end
`endif

endmodule

// File: tb/tb_checked_adder_sequencer.sv
// -----------------------------------------------------------------------------
// tb_checked_adder_sequencer
//
// Self-checking bench for checked_adder_sequencer (SETTLE_CYC=1, MAX_RETRY=2).
// The bench plays the role of the duplicated datapath: it computes the
// arithmetic result from the requested operands and injects a chosen kind of
// fault into the first k attempts of a transaction. The expected response
// (status, retries, sum, latency) follows from k and the retry limit.
// Inputs are driven on the falling edge, outputs checked on the falling edge.
// -----------------------------------------------------------------------------
module tb_checked_adder_sequencer;

   localparam int MAX_RETRY  = 2;
   localparam int SETTLE_CYC = 1;
   localparam int ERRCNT_W   = 8;

   logic       clk;
   logic       rst_n;
   logic       req_valid;
   logic       req_ready;
   logic [2:0] req_a;
   logic [2:0] req_b;
   logic [1:0] req_op;
   logic [2:0] dp_a;
   logic [2:0] dp_b;
   logic       dp_par;
   logic [2:0] dp_c;
   logic [3:0] dp_x;
   logic [1:0] dp_xe;
   logic [3:0] dp_y;
   logic [1:0] dp_ye;
   logic       rsp_valid;
   logic       rsp_ready;
   logic [3:0] rsp_sum;
   logic [1:0] rsp_status;
   logic [1:0] rsp_retries;
`ifdef CHK_ERR_CNT_EN
   logic                err_cnt_clr;
   logic [ERRCNT_W-1:0] err_cnt;
   int                  exp_err;
`endif

   int n_chk  = 0;
   int n_fail = 0;

   checked_adder_sequencer #(
      .MAX_RETRY (MAX_RETRY),
      .SETTLE_CYC(SETTLE_CYC),
      .ERRCNT_W  (ERRCNT_W)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_a      (req_a),
      .req_b      (req_b),
      .req_op     (req_op),
      .dp_a       (dp_a),
      .dp_b       (dp_b),
      .dp_par     (dp_par),
      .dp_c       (dp_c),
      .dp_x       (dp_x),
      .dp_xe      (dp_xe),
      .dp_y       (dp_y),
      .dp_ye      (dp_ye),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_sum    (rsp_sum),
      .rsp_status (rsp_status),
      .rsp_retries(rsp_retries)
`ifdef CHK_ERR_CNT_EN
      ,
      .err_cnt_clr(err_cnt_clr),
      .err_cnt    (err_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Arithmetic the datapath is supposed to perform, as a 4-bit {carry, value}.
   function automatic logic [3:0] dp_result(input logic [2:0] a, input logic [2:0] b,
                                            input logic [1:0] op);
      case (op)
         2'b00:   return {1'b0, a} + {1'b0, b};
         2'b01:   return {1'b0, a} - {1'b0, b};
         2'b10:   return {1'b0, b} - {1'b0, a};
         default: return 4'h0;
      endcase
   endfunction

   function automatic logic [2:0] exp_code(input logic [1:0] op);
      case (op)
         2'b00:   return 3'b001;
         2'b01:   return 3'b010;
         2'b10:   return 3'b100;
         default: return 3'b000;
      endcase
   endfunction

   // Datapath model outputs. Fault kinds: 0 X checker trips and X is corrupted,
   // 1 Y checker trips, 2 copies disagree (Y off by one bit).
   task automatic set_dp(input logic [3:0] res, input bit fault, input int kind);
      dp_x  = res;
      dp_y  = res;
      dp_xe = 2'b10;
      dp_ye = 2'b10;
      if (fault) begin
         case (kind)
            0:       begin dp_xe = 2'b01; dp_x = ~res; end
            1:       dp_ye = 2'b11;
            default: dp_y = res ^ 4'b0001;
         endcase
      end
   endtask

   // One complete transaction starting on a falling edge with the DUT idle.
   // k = number of leading attempts that see a fault (k > MAX_RETRY: all do).
   task automatic run_txn(input logic [2:0] a, input logic [2:0] b, input logic [1:0] op,
                          input int k, input int kind, input int stall,
                          output logic [3:0] o_sum, output logic [1:0] o_status,
                          output logic [1:0] o_retries, output logic [2:0] o_c,
                          output logic o_par);
      bit         legal;
      int         attempts;
      int         lat;
      int         fails;
      logic [3:0] res;
      logic [3:0] e_sum;
      logic [1:0] e_status;
      logic [1:0] e_retries;
      logic [2:0] e_c;

      legal     = (op != 2'b11);
      res       = dp_result(a, b, op);
      attempts  = (k > MAX_RETRY) ? MAX_RETRY + 1 : k + 1;
      fails     = legal ? ((k > MAX_RETRY) ? MAX_RETRY + 1 : k) : 0;
      lat       = legal ? (SETTLE_CYC + 1) * attempts : 0;
      e_status  = !legal ? 2'b11 : (k > MAX_RETRY) ? 2'b10 : (k == 0) ? 2'b00 : 2'b01;
      e_retries = legal ? 2'(attempts - 1) : 2'd0;
      e_sum     = !legal ? 4'h0 : ((k > MAX_RETRY) && (kind == 0)) ? ~res : res;
      e_c       = exp_code(op);

      req_a     = a;
      req_b     = b;
      req_op    = op;
      req_valid = 1'b1;
      rsp_ready = 1'b0;
      set_dp(res, 1'b0, kind);
      chk("req_ready_idle", 32'(req_ready), 32'd1);
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      req_a     = 3'($urandom);
      req_b     = 3'($urandom);
      req_op    = 2'($urandom);

      for (int t = 0; t < lat; t++) begin
         set_dp(res, (t / (SETTLE_CYC + 1)) < k, kind);
         chk("req_ready_busy", 32'(req_ready), 32'd0);
         chk("rsp_valid_early", 32'(rsp_valid), 32'd0);
         chk("dp_c_busy", 32'(dp_c), 32'(e_c));
         chk("dp_a", 32'(dp_a), 32'(a));
         chk("dp_b", 32'(dp_b), 32'(b));
         chk("dp_par", 32'(dp_par), 32'(^{a, b}));
         @(posedge clk);
         @(negedge clk);
      end
      set_dp(4'h0, 1'b0, 0);

`ifdef CHK_ERR_CNT_EN
      exp_err = (exp_err + fails > 255) ? 255 : exp_err + fails;
`endif

      o_sum     = rsp_sum;
      o_status  = rsp_status;
      o_retries = rsp_retries;
      o_c       = dp_c;
      o_par     = dp_par;
      for (int s = 0; s <= stall; s++) begin
         chk("rsp_valid", 32'(rsp_valid), 32'd1);
         chk("rsp_sum", 32'(rsp_sum), 32'(e_sum));
         chk("rsp_status", 32'(rsp_status), 32'(e_status));
         chk("rsp_retries", 32'(rsp_retries), 32'(e_retries));
         chk("req_ready_resp", 32'(req_ready), 32'd0);
         chk("dp_c_resp", 32'(dp_c), 32'(e_c));
`ifdef CHK_ERR_CNT_EN
         chk("err_cnt", 32'(err_cnt), 32'(exp_err));
`endif
         if (s == stall) rsp_ready = 1'b1;
         @(posedge clk);
         @(negedge clk);
      end
      rsp_ready = 1'b0;
      chk("rsp_valid_done", 32'(rsp_valid), 32'd0);
      chk("req_ready_done", 32'(req_ready), 32'd1);
      chk("dp_c_done", 32'(dp_c), 32'd0);
   endtask

   logic [3:0] g_sum;
   logic [1:0] g_status;
   logic [1:0] g_retries;
   logic [2:0] g_c;
   logic       g_par;

   initial begin
      rst_n     = 1'b0;
      req_valid = 1'b0;
      req_a     = '0;
      req_b     = '0;
      req_op    = '0;
      rsp_ready = 1'b0;
      set_dp(4'h0, 1'b0, 0);
`ifdef CHK_ERR_CNT_EN
      err_cnt_clr = 1'b0;
      exp_err     = 0;
`endif

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_req_ready", 32'(req_ready), 32'd1);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_dp_c", 32'(dp_c), 32'd0);
      chk("rst_dp_a", 32'(dp_a), 32'd0);
      chk("rst_dp_b", 32'(dp_b), 32'd0);
      chk("rst_rsp_status", 32'(rsp_status), 32'd0);
`ifdef CHK_ERR_CNT_EN
      chk("rst_err_cnt", 32'(err_cnt), 32'd0);
`endif
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_req_ready", 32'(req_ready), 32'd1);

      // 3 + 2, clean
      run_txn(3'd3, 3'd2, 2'b00, 0, 0, 0, g_sum, g_status, g_retries, g_c, g_par);
      chk("lit_add_sum", 32'(g_sum), 32'h5);
      chk("lit_add_status", 32'(g_status), 32'h0);
      chk("lit_add_retries", 32'(g_retries), 32'h0);
      chk("lit_add_dp_c", 32'(g_c), 32'h1);
      chk("lit_add_par", 32'(g_par), 32'h1);

      // 5 - 1, first attempt Y checker trips
      run_txn(3'd5, 3'd1, 2'b01, 1, 1, 0, g_sum, g_status, g_retries, g_c, g_par);
      chk("lit_sub_sum", 32'(g_sum), 32'h4);
      chk("lit_sub_status", 32'(g_status), 32'h1);
      chk("lit_sub_retries", 32'(g_retries), 32'h1);
      chk("lit_sub_dp_c", 32'(g_c), 32'h2);

      // Persistent copy disagreement: X=0101, Y=0100 on every attempt
`ifdef CHK_ERR_CNT_EN
      err_cnt_clr = 1'b1;
      @(negedge clk);
      err_cnt_clr = 1'b0;
      exp_err     = 0;
`endif
      run_txn(3'd3, 3'd2, 2'b00, 3, 2, 0, g_sum, g_status, g_retries, g_c, g_par);
      chk("lit_fail_sum", 32'(g_sum), 32'h5);
      chk("lit_fail_status", 32'(g_status), 32'h2);
      chk("lit_fail_retries", 32'(g_retries), 32'h2);
`ifdef CHK_ERR_CNT_EN
      chk("lit_err_cnt", 32'(err_cnt), 32'd3);
      err_cnt_clr = 1'b1;
      @(negedge clk);
      err_cnt_clr = 1'b0;
      exp_err     = 0;
      chk("lit_err_cnt_clr", 32'(err_cnt), 32'd0);
`endif

      // Illegal op: answered in the cycle following the accept, datapath idle
      run_txn(3'd6, 3'd1, 2'b11, 0, 0, 0, g_sum, g_status, g_retries, g_c, g_par);
      chk("lit_ill_status", 32'(g_status), 32'h3);
      chk("lit_ill_sum", 32'(g_sum), 32'h0);
      chk("lit_ill_dp_c", 32'(g_c), 32'h0);

      // Response held for 5 extra cycles
      run_txn(3'd7, 3'd4, 2'b10, 0, 0, 5, g_sum, g_status, g_retries, g_c, g_par);
      chk("lit_bsa_sum", 32'(g_sum), 32'hd);
      chk("lit_bsa_dp_c", 32'(g_c), 32'h4);

      // Reset while driving the datapath: request is dropped
      req_a     = 3'd7;
      req_b     = 3'd7;
      req_op    = 2'b10;
      req_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      chk("mid_dp_c_driving", 32'(dp_c), 32'h4);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_dp_c", 32'(dp_c), 32'd0);
      chk("mid_rst_dp_a", 32'(dp_a), 32'd0);
      chk("mid_rst_req_ready", 32'(req_ready), 32'd1);
      chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
`ifdef CHK_ERR_CNT_EN
      exp_err = 0;
`endif
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("mid_rst_no_rsp", 32'(rsp_valid), 32'd0);
         chk("mid_rst_idle", 32'(req_ready), 32'd1);
      end

      // Randomized traffic
      for (int n = 0; n < 200; n++) begin
         run_txn(3'($urandom), 3'($urandom), 2'($urandom_range(0, 3)),
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
                 int'($urandom_range(0, 3)),
                 g_sum, g_status, g_retries, g_c, g_par);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
